// File: rtl/riscv_fetch_buf_pkg.sv
// Shared defaults and helpers for the instruction-fetch front end (riscv_fetch_buf).
package riscv_fetch_buf_pkg;

    localparam int          FETCH_ADDR_W_DEFAULT = 32;
    localparam int          FETCH_INST_W_DEFAULT = 32;
    localparam int          FETCH_DEPTH_DEFAULT  = 4;
    localparam logic [31:0] RESET_PC_DEFAULT     = 32'h0000_0000;
    localparam int          PC_STEP_DEFAULT      = 4;
    localparam int          PERF_CNT_W           = 32;

    // Counters that must hold the values 0..depth inclusive need one extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Show-ahead FIFO used as the fetch buffer: the head entry is visible on rdata
// whenever empty is low. flush clears it and overrides any push or pop in that cycle.
module riscv_fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointer and occupancy update; a full buffer still takes a push when it pops.
    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        empty    = (count_q == '0);
        do_push  = push && !flush && (!full || pop);
        do_pop   = pop && !flush && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful under a valid count, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/riscv_fetch_buf.sv
// Instruction-fetch front end: issues sequential fetches over a req/gnt + rvalid
// bus, buffers returned instructions with their PCs, and hands them to decode over
// valid/ready. Redirects flush the buffer and discard responses still in flight.
// Optional build macro RISCV_FETCH_PERF_EN adds stall_cnt_o and flush_cnt_o.
module riscv_fetch_buf
    import riscv_fetch_buf_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W_DEFAULT,
    parameter int                INST_W   = FETCH_INST_W_DEFAULT,
    parameter int                DEPTH    = FETCH_DEPTH_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter int                PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    input  logic              inst_ready_i
`ifdef RISCV_FETCH_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cnt_o,
    output logic [PERF_CNT_W-1:0] flush_cnt_o
`endif
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int SUM_W = CNT_W + 1;
    localparam int ENT_W = INST_W + ADDR_W;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]  out_q, out_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [INST_W-1:0] last_inst_q, last_inst_d;
    logic [ADDR_W-1:0] last_pc_q, last_pc_d;

    logic              issue;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [ENT_W-1:0]  fifo_wdata;
    logic [ENT_W-1:0]  fifo_rdata;
    logic [INST_W-1:0] head_inst;
    logic [ADDR_W-1:0] head_pc;

    // Issue gating: buffered plus outstanding may never exceed DEPTH, with no
    // credit for a same-cycle pop; a redirect cycle never requests.
    always_comb begin
        imem_req_o  = rst
                   && (({1'b0, fifo_cnt} + {1'b0, out_q}) < SUM_W'(DEPTH))
                   && !redirect_i;
        imem_addr_o = fetch_pc_q;
        issue       = imem_req_o && imem_gnt_i;
    end

    // Response steering: keep a response only when nothing is left to drop and
    // no redirect is flushing this cycle; a flush also suppresses the pop.
    always_comb begin
        push       = imem_rvalid_i && !redirect_i && (drop_q == '0);
        pop        = inst_valid_o && inst_ready_i && !redirect_i;
        fifo_wdata = {imem_rdata_i, rsp_pc_q};
    end

    // PC, outstanding and drop counters; on redirect everything still in flight
    // after this cycle's traffic becomes a response to discard.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_d     = drop_q;
        out_d      = out_q + CNT_W'(issue) - CNT_W'(imem_rvalid_i);
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            rsp_pc_d   = redirect_pc_i;
            drop_d     = out_d;
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
            if (imem_rvalid_i) begin
                if (drop_q != '0) drop_d   = drop_q - CNT_W'(1);
                else              rsp_pc_d = rsp_pc_q + ADDR_W'(PC_STEP);
            end
        end
    end

    // Decode-facing head: show the buffer head when valid, otherwise hold the
    // last head that was presented.
    always_comb begin
        {head_inst, head_pc} = fifo_rdata;
        inst_valid_o = !fifo_empty;
        last_inst_d  = last_inst_q;
        last_pc_d    = last_pc_q;
        if (inst_valid_o) begin
            last_inst_d = head_inst;
            last_pc_d   = head_pc;
        end
        inst_o    = inst_valid_o ? head_inst : last_inst_q;
        inst_pc_o = inst_valid_o ? head_pc   : last_pc_q;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q  <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            out_q       <= '0;
            drop_q      <= '0;
            last_inst_q <= '0;
            last_pc_q   <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            out_q       <= out_d;
            drop_q      <= drop_d;
            last_inst_q <= last_inst_d;
            last_pc_q   <= last_pc_d;
        end
    end

    riscv_fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_i),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    // The issue cap makes a push into a full, non-popping buffer impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && fifo_full && !pop));

`ifdef RISCV_FETCH_PERF_EN
    logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Decode-starved cycles and redirect pulses, both wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (inst_ready_i && !inst_valid_o) stall_cnt_d = stall_cnt_q + PERF_CNT_W'(1);
        if (redirect_i)                    flush_cnt_d = flush_cnt_q + PERF_CNT_W'(1);
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_fetch_buf.sv
// Bench for riscv_fetch_buf: in-order variable-latency memory plus a queue-based
// reference of the instruction stream decode should see.
`timescale 1ns/1ps
module tb_riscv_fetch_buf;

    localparam int          ADDR_W   = 32;
    localparam int          INST_W   = 32;
    localparam int          DEPTH    = 4;
    localparam int          PC_STEP  = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i    = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i  = '0;
    logic        redirect_i    = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i  = 1'b0;
`ifdef RISCV_FETCH_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
`endif

    riscv_fetch_buf #(
        .ADDR_W   (ADDR_W),
        .INST_W   (INST_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_ready_i  (inst_ready_i)
`ifdef RISCV_FETCH_PERF_EN
        ,
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

    req_t        inflight[$];
    ent_t        mq[$];
    logic [31:0] gnt_addrs[$];
    logic [31:0] exp_addr, last_pc, last_inst;
    logic [31:0] m_stall, m_flush;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          lat_min = 1, lat_max = 1;
    int          grant_cnt, first_gnt, first_vld;
    logic        gnt_d, ready_d, redir_d;
    logic [31:0] tgt_d;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h0F1E};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, compare at negedge+1, update the reference after posedge.
    task automatic cycle();
        req_t        r;
        ent_t        e;
        logic        req_s, gnt_s, rv_s, ready_s, redir_s, mvalid, exp_req;
        logic [31:0] addr_s, tgt_s;
        int          lat;
        @(negedge clk);
        cyc++;
        imem_gnt_i    = gnt_d;
        inst_ready_i  = ready_d;
        redirect_i    = redir_d;
        redirect_pc_i = tgt_d;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        if (inflight.size() > 0 && inflight[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = inst_of(inflight[0].addr);
        end
        #1;
        mvalid  = (mq.size() > 0);
        exp_req = ((mq.size() + inflight.size()) < DEPTH) && !redirect_i;
        check_eq("req", imem_req_o, exp_req);
        check_eq("addr", imem_addr_o, exp_addr);
        check_eq("valid", inst_valid_o, mvalid);
        if (mvalid) begin
            last_pc   = mq[0].pc;
            last_inst = mq[0].inst;
        end
        check_eq("pc", inst_pc_o, last_pc);
        check_eq("inst", inst_o, last_inst);
        if (imem_req_o && imem_gnt_i && first_gnt < 0) first_gnt = cyc;
        if (inst_valid_o && first_vld < 0) first_vld = cyc;
        req_s = imem_req_o; gnt_s = imem_gnt_i; addr_s = imem_addr_o;
        rv_s = imem_rvalid_i; ready_s = inst_ready_i; redir_s = redirect_i; tgt_s = redirect_pc_i;
        if (ready_s && !mvalid) m_stall++;
        if (redir_s) m_flush++;
        @(posedge clk);
        if (mvalid && ready_s && !redir_s) void'(mq.pop_front());
        if (rv_s && inflight.size() > 0) begin
            r = inflight.pop_front();
            if (!redir_s && !r.stale) begin
                e.pc   = r.addr;
                e.inst = inst_of(r.addr);
                mq.push_back(e);
            end
        end
        if (req_s && gnt_s) begin
            lat = int'($urandom_range(lat_max, lat_min));
            r.addr = addr_s; r.due = cyc + lat; r.stale = 1'b0;
            inflight.push_back(r);
            gnt_addrs.push_back(addr_s);
            grant_cnt++;
            exp_addr = exp_addr + PC_STEP;
        end
        if (redir_s) begin
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            mq.delete();
            exp_addr = tgt_s;
        end
    endtask

    // Asynchronous reset away from any clock edge; memory shares it and forgets its requests.
    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; redirect_i = 1'b0; inst_ready_i = 1'b0;
        #1;
        check_eq("rst_req", imem_req_o, 1'b0);
        check_eq("rst_addr", imem_addr_o, RESET_PC);
        check_eq("rst_valid", inst_valid_o, 1'b0);
        check_eq("rst_inst", inst_o, 32'h0);
        check_eq("rst_pc", inst_pc_o, 32'h0);
`ifdef RISCV_FETCH_PERF_EN
        check_eq("rst_stall", stall_cnt_o, 32'h0);
        check_eq("rst_flush", flush_cnt_o, 32'h0);
`endif
        inflight.delete(); mq.delete(); gnt_addrs.delete();
        exp_addr = RESET_PC; last_pc = '0; last_inst = '0;
        m_stall = '0; m_flush = '0;
        grant_cnt = 0; first_gnt = -1; first_vld = -1;
        gnt_d = 1'b0; ready_d = 1'b0; redir_d = 1'b0; tgt_d = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic rand_cycle();
        logic [31:0] t;
        gnt_d   = ($urandom % 4) != 0;
        ready_d = ($urandom % 3) != 0;
        redir_d = ($urandom % 20) == 0;
        t = $urandom & 32'hFFFF_FFFC;
        if (($urandom % 4) == 0) t = 32'hFFFF_FFF0 | (t & 32'hC);
        tgt_d = t;
        cycle();
    endtask

    initial begin
        int n;
        gnt_d = 0; ready_d = 0; redir_d = 0; tgt_d = '0;

        // Streaming: addresses 0,4,8..., valid two cycles after the first grant.
        apply_reset();
        gnt_d = 1; ready_d = 1; lat_min = 1; lat_max = 1;
        repeat (20) cycle();
        check_eq("t1_vld_latency", 64'(first_vld - first_gnt), 64'd2);

        // Decode stalled: issue stops at DEPTH, one pop frees one request.
        apply_reset();
        gnt_d = 1; ready_d = 0;
        repeat (10) cycle();
        check_eq("t2_grants", grant_cnt, DEPTH);
        #1 check_eq("t2_req_off", imem_req_o, 1'b0);
        ready_d = 1; cycle(); ready_d = 0;
        repeat (6) cycle();
        check_eq("t2_grants_after_pop", grant_cnt, DEPTH + 1);

        // Redirect with two slow responses in flight.
        apply_reset();
        gnt_d = 1; ready_d = 1; lat_min = 3; lat_max = 3;
        n = 0;
        while (inflight.size() != 2 && n < 20) begin cycle(); n++; end
        check_eq("t3_out_two", inflight.size(), 2);
        redir_d = 1; tgt_d = 32'h100; cycle(); redir_d = 0;
        n = 0;
        do begin cycle(); #1; n++; end while (!inst_valid_o && n < 30);
        check_eq("t3_wait_valid", inst_valid_o, 1'b1);
        check_eq("t3_first_pc", inst_pc_o, 32'h100);
        check_eq("t3_first_inst", inst_o, inst_of(32'h100));

        // Redirect coinciding with a response and a pop.
        apply_reset();
        gnt_d = 1; ready_d = 1; lat_min = 2; lat_max = 2;
        repeat (8) cycle();
        redir_d = 1; tgt_d = 32'h200; cycle(); redir_d = 0;
        #1 check_eq("t4_flushed", inst_valid_o, 1'b0);
        n = 0;
        do begin cycle(); #1; n++; end while (!inst_valid_o && n < 30);
        check_eq("t4_wait_valid", inst_valid_o, 1'b1);
        check_eq("t4_first_pc", inst_pc_o, 32'h200);

        // Fetch address wraps past the top of the address space.
        apply_reset();
        gnt_d = 1; ready_d = 1; lat_min = 1; lat_max = 1;
        redir_d = 1; tgt_d = 32'hFFFF_FFF8; cycle(); redir_d = 0;
        gnt_addrs.delete();
        repeat (5) cycle();
        if (gnt_addrs.size() < 3) check_eq("t5_grants", gnt_addrs.size(), 3);
        else begin
            check_eq("t5_addr0", gnt_addrs[0], 32'hFFFF_FFF8);
            check_eq("t5_addr1", gnt_addrs[1], 32'hFFFF_FFFC);
            check_eq("t5_addr2", gnt_addrs[2], 32'h0000_0000);
        end

        // Random traffic, then reset in the middle of a burst.
        lat_min = 1; lat_max = 5;
        repeat (60) rand_cycle();
        apply_reset();

        // Long random run.
        lat_min = 1; lat_max = 5;
        repeat (3000) rand_cycle();
`ifdef RISCV_FETCH_PERF_EN
        #1;
        check_eq("stall_cnt", stall_cnt_o, m_stall);
        check_eq("flush_cnt", flush_cnt_o, m_flush);
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
